// File: rtl/button_conditioner_if.sv
// Button conditioner CPU-side bundle: raw pins in, debounced levels and
// sticky press events out, masked acknowledge back from the CPU.
interface button_conditioner_if #(
    parameter int unsigned NUM_BTN = 7
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_pressed;
    logic               ack;
    logic [NUM_BTN-1:0] ack_mask;
    logic               irq;

    modport master (
        output btn_raw,
        output ack,
        output ack_mask,
        input  btn_level,
        input  btn_pressed,
        input  irq
    );

    modport slave (
        input  btn_raw,
        input  ack,
        input  ack_mask,
        output btn_level,
        output btn_pressed,
        output irq
    );
endinterface

// File: rtl/button_conditioner.sv
// Push-button input stage: per-button 2-flop synchronizer and debounce FSM,
// sticky press events cleared by masked acknowledge, and a pending-press irq.
module button_conditioner #(
    parameter int unsigned NUM_BTN         = 7,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_WIDTH       = 18
) (
    input logic                 clk_25mhz,
    input logic                 reset,
    button_conditioner_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {StStable0, StStable1} state_e;

    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] level_d;
    logic [NUM_BTN-1:0] set_evt;
    logic [NUM_BTN-1:0] clr_evt;
    logic [NUM_BTN-1:0] pressed_d;
    logic [NUM_BTN-1:0] pressed_q;
    logic               irq_q;

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        state_e               state_q;
        state_e               state_d;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic [CNT_WIDTH-1:0] cnt_d;

        always_ff @(posedge clk_25mhz or posedge reset) begin
            if (reset) begin
                state_q <= StStable0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Counter only advances while the synchronized input disagrees with the
        // accepted level; any agreement restarts it, so it never wraps.
        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            case (state_q)
                StStable0: begin
                    if (sync2_q[i]) begin
                        if (cnt_q == CntMax) begin
                            state_d = StStable1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                StStable1: begin
                    if (!sync2_q[i]) begin
                        if (cnt_q == CntMax) begin
                            state_d = StStable0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = StStable0;
            endcase
        end

        always_comb begin
            level[i]   = (state_q == StStable1);
            level_d[i] = (state_d == StStable1);
        end
    end

    // The set term comes from the next level so the event and irq appear on the
    // same edge as the level; set wins over a coincident clear.
    always_comb begin
        set_evt   = level_d & ~level;
        clr_evt   = bus.ack_mask & {NUM_BTN{bus.ack}};
        pressed_d = set_evt | (pressed_q & ~clr_evt);
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            pressed_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            pressed_q <= pressed_d;
            irq_q     <= |pressed_d;
        end
    end

    assign bus.btn_level   = level;
    assign bus.btn_pressed = pressed_q;
    assign bus.irq         = irq_q;
endmodule
